// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : Instruction-fetch sequencer with a one-cycle-latency memory and a
//            prefetch FIFO that delivers {instruction, pc} over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter int            DW     = 16,
    parameter int            AW     = 16,
    parameter int            DEPTH  = 4,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_dout,
    input  logic                   en,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    output logic                   ins_valid,
    output logic [DW-1:0]          ins_data,
    output logic [AW-1:0]          ins_pc,
    input  logic                   ins_ready,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

    logic [AW-1:0]      r_fetch_pc;
    logic               r_req;
    logic [AW-1:0]      r_req_pc;
    logic [DW-1:0]      r_fifo_data [DEPTH];
    logic [AW-1:0]      r_fifo_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_CNT_W:0]   w_pending;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // The in-flight read reserves a slot, so a capture always has room.
    assign w_pending = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_req};
    assign w_issue   = redirect | (en & (w_pending < c_DEPTH_EXT));
    assign w_push    = r_req & ~redirect;
    assign w_pop     = ins_valid & ins_ready & ~redirect;

    assign mem_addr  = redirect ? redirect_pc : r_fetch_pc;
    assign ins_valid = (r_count != '0);
    assign ins_data  = ins_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign ins_pc    = ins_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign fill      = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RST_PC;
            r_req      <= 1'b0;
            r_req_pc   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_req <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= mem_addr + AW'(1);
                r_req_pc   <= mem_addr;
            end
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_dout;
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule
`default_nettype wire
